// File: rtl/control_cabina.sv
// Elevator cabin controller: tracks the current floor, times floor-to-floor
// travel and door-open intervals, and follows motor commands from dispatch.
module control_cabina #(
   parameter int N_PISOS      = 10,
   parameter int TICKS_PISO   = 8,
   parameter int TICKS_PUERTA = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] motor,
   output logic [3:0] piso,
   output logic       cambio_piso,
   output logic       esperar,
   output logic [1:0] estado
);

   localparam int CNT_W = (TICKS_PISO   > 2) ? $clog2(TICKS_PISO)   : 1;
   localparam int TMR_W = (TICKS_PUERTA > 2) ? $clog2(TICKS_PUERTA) : 1;

   localparam logic [1:0] DETENIDO = 2'b00;
   localparam logic [1:0] SUBIENDO = 2'b01;
   localparam logic [1:0] BAJANDO  = 2'b10;
   localparam logic [1:0] PUERTA   = 2'b11;

   localparam logic [1:0] CMD_SUBIR = 2'b01;
   localparam logic [1:0] CMD_BAJAR = 2'b10;
   localparam logic [1:0] CMD_ABRIR = 2'b11;

   localparam logic [3:0]       PISO_MAX = 4'(N_PISOS - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PISO - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TICKS_PUERTA - 1);

   logic [1:0]       estado_q, estado_d;
   logic [3:0]       piso_q, piso_d, piso_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             cambio_q, cambio_d;
   logic             esperar_q, esperar_d;

   // Next-state, floor, travel counter and door timer computation.
   always_comb begin
      estado_d = estado_q;
      piso_d   = piso_q;
      piso_nxt = piso_q;
      cnt_d    = cnt_q;
      tmr_d    = tmr_q;
      cambio_d = 1'b0;
      case (estado_q)
         DETENIDO: begin
            if (motor == CMD_SUBIR && piso_q < PISO_MAX) begin
               estado_d = SUBIENDO;
               cnt_d    = '0;
            end else if (motor == CMD_BAJAR && piso_q != 4'd0) begin
               estado_d = BAJANDO;
               cnt_d    = '0;
            end else if (motor == CMD_ABRIR) begin
               estado_d = PUERTA;
               tmr_d    = '0;
            end else begin
               estado_d = DETENIDO;
            end
         end
         SUBIENDO: begin
            if (cnt_q == CNT_LAST) begin
               // Arrival: the decision is judged against the floor just reached.
               piso_nxt = (piso_q < PISO_MAX) ? piso_q + 4'd1 : piso_q;
               piso_d   = piso_nxt;
               cambio_d = 1'b1;
               cnt_d    = '0;
               if (motor == CMD_SUBIR && piso_nxt < PISO_MAX) begin
                  estado_d = SUBIENDO;
               end else if (motor == CMD_ABRIR) begin
                  estado_d = PUERTA;
                  tmr_d    = '0;
               end else begin
                  estado_d = DETENIDO;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         BAJANDO: begin
            if (cnt_q == CNT_LAST) begin
               piso_nxt = (piso_q != 4'd0) ? piso_q - 4'd1 : piso_q;
               piso_d   = piso_nxt;
               cambio_d = 1'b1;
               cnt_d    = '0;
               if (motor == CMD_BAJAR && piso_nxt != 4'd0) begin
                  estado_d = BAJANDO;
               end else if (motor == CMD_ABRIR) begin
                  estado_d = PUERTA;
                  tmr_d    = '0;
               end else begin
                  estado_d = DETENIDO;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         PUERTA: begin
            // Only a door-hold request is honoured while the doors are open.
            if (motor == CMD_ABRIR) begin
               tmr_d = '0;
            end else if (tmr_q == TMR_LAST) begin
               estado_d = DETENIDO;
               tmr_d    = '0;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         default: begin
            estado_d = DETENIDO;
            cnt_d    = '0;
            tmr_d    = '0;
         end
      endcase
      esperar_d = (estado_d == PUERTA);
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q  <= DETENIDO;
         piso_q    <= 4'd0;
         cnt_q     <= '0;
         tmr_q     <= '0;
         cambio_q  <= 1'b0;
         esperar_q <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         piso_q    <= piso_d;
         cnt_q     <= cnt_d;
         tmr_q     <= tmr_d;
         cambio_q  <= cambio_d;
         esperar_q <= esperar_d;
      end
   end

   assign estado      = estado_q;
   assign piso        = piso_q;
   assign cambio_piso = cambio_q;
   assign esperar     = esperar_q;

endmodule

// File: doc/control_cabina.md
CONTROL_CABINA -- requirements
Module: control_cabina

Interface
REQ-001 Parameter N_PISOS, default 10: number of floors, indexed 0..N_PISOS-1.
REQ-002 Parameter TICKS_PISO, default 8: clock cycles needed to travel one floor; minimum 2.
REQ-003 Parameter TICKS_PUERTA, default 16: clock cycles the doors stay open; minimum 2.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 motor  input  2  command from the dispatch algorithm: 00 parar, 01 subir, 10 bajar, 11 abrir puertas.
REQ-007 piso  output  4  current floor, binary, 0..N_PISOS-1.
REQ-008 cambio_piso  output  1  one-cycle pulse on each floor arrival.
REQ-009 esperar  output  1  high while the doors are open.
REQ-010 estado  output  2  cabin state: 00 DETENIDO, 01 SUBIENDO, 10 BAJANDO, 11 PUERTA.

Function
REQ-011 The block SHALL implement a four-state FSM (DETENIDO, SUBIENDO, BAJANDO, PUERTA), encoded on estado as listed in REQ-010.
REQ-012 The block SHALL hold a travel counter cnt and a door timer tmr, each wide enough for its parameter.
REQ-013 DETENIDO transitions SHALL be:
- motor=01 and piso<N_PISOS-1 -> SUBIENDO, cnt=0.
- motor=10 and piso>0 -> BAJANDO, cnt=0.
- motor=11 -> PUERTA, tmr=0.
- otherwise stay; this includes 01 at the top floor and 10 at floor 0.
REQ-014 In SUBIENDO and BAJANDO, cnt SHALL increment every cycle.
REQ-015 On the cycle cnt==TICKS_PISO-1, the block SHALL:
- update piso by +1 (SUBIENDO) or -1 (BAJANDO);
- assert cambio_piso for that one registered cycle;
- reset cnt to 0.
REQ-016 Before the arrival cycle of REQ-015, the block SHALL ignore motor; the cabin never stops between floors, and a reversal request mid-travel has no effect.
REQ-017 On the arrival cycle, the next state SHALL follow from the motor value sampled that cycle, judged against the new floor:
- same direction still held and travel possible -> continue;
- 11 -> PUERTA;
- anything else -> DETENIDO.
REQ-018 SUBIENDO SHALL never move piso above N_PISOS-1, and BAJANDO SHALL never move it below 0; reaching either end forces DETENIDO (or PUERTA if motor=11).
REQ-019 In PUERTA, esperar SHALL be 1 and tmr SHALL increment every cycle.
REQ-020 In PUERTA, motor=11 SHALL reload tmr to 0 (door hold).
REQ-021 In PUERTA, the block SHALL return to DETENIDO on the cycle after tmr reaches TICKS_PUERTA-1 with motor!=11.
REQ-022 In PUERTA, the block SHALL ignore motor values 01, 10 and 00.
REQ-023 Total door time without hold SHALL be exactly TICKS_PUERTA cycles of esperar=1.
REQ-024 Floor-to-floor latency SHALL be TICKS_PISO cycles from entering a moving state to the cambio_piso pulse.
REQ-025 All outputs SHALL be registered, with no combinational path from motor.

Reset
REQ-026 While rst_n=0, the block SHALL asynchronously force: estado=DETENIDO, piso=0, cnt=0, tmr=0, cambio_piso=0, esperar=0.
REQ-027 Reset asserted mid-travel or with the doors open SHALL abandon the operation and return to floor 0 with no cambio_piso pulse.
REQ-028 After rst_n deasserts, the first command SHALL be sampled on the first rising edge.

Verification (TICKS_PISO=4, TICKS_PUERTA=3, N_PISOS=10)
REQ-029 After reset, hold motor=01 -> cambio_piso pulses every 4 cycles, piso steps 0,1,...,9, and estado=DETENIDO after the arrival at 9 with no further pulse.
REQ-030 Hold motor=10 at piso=0 -> estado stays 00, piso stays 0, no cambio_piso.
REQ-031 From piso=3, motor=01 for 1 cycle then 00 -> exactly one pulse 4 cycles later, piso=4, estado=DETENIDO.
REQ-032 From piso=2 moving up, drive motor=10 mid-travel and 11 on the arrival cycle -> piso=3, estado=PUERTA, esperar high 3 cycles, then DETENIDO.
REQ-033 In PUERTA, pulse motor=11 at tmr=2 -> esperar stays high 3 further cycles; motor=01 during PUERTA has no effect.
REQ-034 Assert rst_n=0 asynchronously at piso=5 mid-travel -> outputs clear immediately (piso=0, estado=00, esperar=0), without waiting for a clock edge.
